clken_ratio_gen: RTL and testbench

- Parametrised successor to the fixed 3-output PLL wrapper. Runs on one PLL output clock and derives NUM_CH fractional clock-enable strobes, each with a runtime-programmable ratio NUM/DEN using a phase accumulator.
- Includes a lock sequencer that gates all strobes until the PLL lock has been stable for LOCK_CYCLES.
- Sits between the PLL wrapper and the core clock-enable fabric. Lets one fast clock replace several PLL outputs and allows retuning, e.g. NTSC/PAL, without re-generating the PLL.

---
 rtl/clken_ratio_gen.sv | 175 +++++++++++++++++
 tb/tb_clken_ratio_gen.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clken_ratio_gen.sv
// Fractional clock-enable generator: NUM_CH phase-accumulator strobes gated by a PLL lock sequencer.
// Optional lock-loss counter (loss_cnt_o / loss_clr_i) is built when CLKEN_LOSS_CNT_EN is defined.
module clken_ratio_gen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [ACC_W-1:0]  cfg_num_i,
    input  logic [ACC_W-1:0]  cfg_den_i,
    output logic              locked_o,
`ifdef CLKEN_LOSS_CNT_EN
    input  logic              loss_clr_i,
    output logic [7:0]        loss_cnt_o,
`endif
    output logic [NUM_CH-1:0] clken_o
);

    localparam int CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_SETTLE    = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic             ready_q, ready_d;
    logic             lk_s;
    logic             run_stay;
    logic             cfg_xfer;

    assign lk_s     = sync_q[1];
    assign cfg_xfer = cfg_valid_i && ready_q;
    // Accumulators advance only on edges that keep us in RUN; the exit edge clears them.
    assign run_stay = (state_q == ST_RUN) && lk_s;

    always_comb begin
        sync_d  = {sync_q[0], pll_locked_i};
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
        locked_d = (state_d == ST_RUN);
        ready_d  = !cfg_xfer;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
        end
    end

    assign locked_o    = locked_q;
    assign cfg_ready_o = ready_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_W-1:0] acc_q, acc_d;
            logic [ACC_W-1:0] num_q, num_d;
            logic [ACC_W-1:0] den_q, den_d;
            logic             clken_q, clken_d;
            logic [ACC_W:0]   sum;
            logic             sel;

            assign sel = cfg_xfer && (cfg_ch_i == CH_W'(gi));
            // One extra bit so acc + num cannot wrap before the compare.
            assign sum = {1'b0, acc_q} + {1'b0, num_q};

            always_comb begin
                num_d   = num_q;
                den_d   = den_q;
                acc_d   = '0;
                clken_d = 1'b0;
                if (run_stay && (den_q != '0) && (num_q != '0)) begin
                    if (num_q >= den_q) begin
                        clken_d = 1'b1;
                    end else if (sum >= {1'b0, den_q}) begin
                        clken_d = 1'b1;
                        acc_d   = ACC_W'(sum - {1'b0, den_q});
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
                if (sel) begin
                    num_d   = cfg_num_i;
                    den_d   = cfg_den_i;
                    acc_d   = '0;
                    clken_d = 1'b0;
                end
            end

            always_ff @(posedge refclk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q   <= '0;
                    num_q   <= '0;
                    den_q   <= ACC_W'(1);
                    clken_q <= 1'b0;
                end else begin
                    acc_q   <= acc_d;
                    num_q   <= num_d;
                    den_q   <= den_d;
                    clken_q <= clken_d;
                end
            end

            assign clken_o[gi] = clken_q;
        end
    endgenerate

`ifdef CLKEN_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == ST_RUN) && !lk_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
        if (loss_clr_i) begin
            loss_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_clken_ratio_gen.sv
// Bench for clken_ratio_gen: ratio vector table, lock/handshake/reset sequences and a randomized run
// checked every cycle against a floor(n*num/den) pulse model with a lock-streak model.
module tb_clken_ratio_gen;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 16;
    localparam int LC     = 8;
    localparam int CH_W   = 2;

    logic              refclk       = 1'b0;
    logic              rst_n        = 1'b0;
    logic              pll_locked_i = 1'b0;
    logic              cfg_valid_i  = 1'b0;
    logic              cfg_ready_o;
    logic [CH_W-1:0]   cfg_ch_i     = '0;
    logic [ACC_W-1:0]  cfg_num_i    = '0;
    logic [ACC_W-1:0]  cfg_den_i    = '0;
    logic              locked_o;
    logic [NUM_CH-1:0] clken_o;
`ifdef CLKEN_LOSS_CNT_EN
    logic              loss_clr_i   = 1'b0;
    logic [7:0]        loss_cnt_o;
`endif

    clken_ratio_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LC)) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_ch_i     (cfg_ch_i),
        .cfg_num_i    (cfg_num_i),
        .cfg_den_i    (cfg_den_i),
        .locked_o     (locked_o),
`ifdef CLKEN_LOSS_CNT_EN
        .loss_clr_i   (loss_clr_i),
        .loss_cnt_o   (loss_cnt_o),
`endif
        .clken_o      (clken_o)
    );

    always #5 refclk = ~refclk;

    int checks = 0;
    int errors = 0;

    // Reference model: lock = enough consecutive synchronised-lock samples;
    // pulse count after n RUN edges = floor(n*num/den).
    bit              m_p1, m_p2, m_locked, m_ready;
    int              m_streak;
    longint          m_n   [NUM_CH];
    longint          m_num [NUM_CH];
    longint          m_den [NUM_CH];
    bit [NUM_CH-1:0] m_clken;
    int              m_loss;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit pulse_at(input longint n, input longint num, input longint den);
        if (den == 0 || num == 0) return 1'b0;
        if (num >= den) return 1'b1;
        return ((n * num) / den) != (((n - 1) * num) / den);
    endfunction

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_locked = 0; m_ready = 0; m_streak = 0;
        m_clken = '0; m_loss = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_n[c] = 0; m_num[c] = 0; m_den[c] = 1;
        end
    endtask

    task automatic model_edge();
        bit lks, was_run, xfer;
        lks  = m_p2;
        m_p2 = m_p1;
        m_p1 = pll_locked_i;
        was_run  = m_locked;
        m_streak = lks ? ((m_streak < LC + 1) ? m_streak + 1 : m_streak) : 0;
        m_locked = (m_streak >= LC + 1);
        xfer     = cfg_valid_i && m_ready;
        m_ready  = !xfer;
        if (was_run && !m_locked && m_loss < 255) m_loss++;
`ifdef CLKEN_LOSS_CNT_EN
        if (loss_clr_i) m_loss = 0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (was_run && m_locked) begin
                m_n[c]++;
                m_clken[c] = pulse_at(m_n[c], m_num[c], m_den[c]);
            end else begin
                m_n[c] = 0;
                m_clken[c] = 1'b0;
            end
            if (xfer && int'(cfg_ch_i) == c) begin
                m_num[c] = cfg_num_i;
                m_den[c] = cfg_den_i;
                m_n[c] = 0;
                m_clken[c] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge refclk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check("clken", clken_o, m_clken);
        check("locked", locked_o, m_locked);
        check("ready", cfg_ready_o, m_ready);
`ifdef CLKEN_LOSS_CNT_EN
        check("loss_cnt", loss_cnt_o, m_loss);
`endif
    endtask

    task automatic wait_locked(input bit lvl, output int edges);
        edges = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (locked_o == lvl) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic send_cfg(input int ch, input int num, input int den);
        cfg_valid_i = 1'b1;
        cfg_ch_i    = CH_W'(ch);
        cfg_num_i   = ACC_W'(num);
        cfg_den_i   = ACC_W'(den);
        step();
        cfg_valid_i = 1'b0;
    endtask

    typedef struct {
        int ch;
        int num;
        int den;
        int cycles;
        int exp_pulses;
        int exp_first;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int e, p0, p1, first0, nrec, drop_left, xfers, first;
        int pos1[3];
        bit rdy[4];

        vecs[0] = '{0, 1, 4, 100, 25, 4};
        vecs[1] = '{1, 3, 7, 700, 300, 3};
        vecs[2] = '{2, 5, 5, 50, 50, 1};
        vecs[3] = '{0, 7, 0, 50, 0, 0};
        vecs[4] = '{1, 0, 9, 50, 0, 0};
        vecs[5] = '{2, 9, 5, 40, 40, 1};
        vecs[6] = '{0, 2, 3, 30, 20, 2};
        vecs[7] = '{2, 40000, 65535, 10, 6, 2};

        model_reset();
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();

        // Ratios programmed while waiting for lock, then lock from cold.
        send_cfg(0, 1, 4);
        step();
        send_cfg(1, 3, 7);
        step();
        pll_locked_i = 1'b1;
        wait_locked(1'b1, e);
        check("lock_latency", e, 2 + 1 + LC);

        p0 = 0; p1 = 0; first0 = 0; nrec = 0;
        for (int k = 1; k <= 700; k++) begin
            step();
            if (clken_o[0] && k <= 100) begin
                p0++;
                if (first0 == 0) first0 = k;
            end
            if (clken_o[1]) begin
                p1++;
                if (nrec < 3) begin
                    pos1[nrec] = k;
                    nrec++;
                end
            end
        end
        check("r1_4_pulses", p0, 25);
        check("r1_4_first", first0, 4);
        check("r3_7_pulses", p1, 300);
        check("r3_7_pos0", pos1[0], 3);
        check("r3_7_pos1", pos1[1], 5);
        check("r3_7_pos2", pos1[2], 7);

        // Ratio table applied in RUN, counted from the transfer edge.
        for (int v = 0; v < 8; v++) begin
            send_cfg(vecs[v].ch, vecs[v].num, vecs[v].den);
            p0 = 0; first = 0;
            for (int k = 1; k <= vecs[v].cycles; k++) begin
                step();
                if (clken_o[vecs[v].ch]) begin
                    p0++;
                    if (first == 0) first = k;
                end
            end
            $display("vec %0d ch=%0d num=%0d den=%0d pulses=%0d first=%0d", v,
                     vecs[v].ch, vecs[v].num, vecs[v].den, p0, first);
            check("vec_pulses", p0, vecs[v].exp_pulses);
            check("vec_first", first, vecs[v].exp_first);
        end

        // Out-of-range channel must leave every channel alone.
        send_cfg(2, 1, 2);
        step();
        send_cfg(3, 1, 1);
        p0 = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (clken_o[2]) p0++;
        end
        check("oob_ch2_pulses", p0, 10);

        // valid held for four cycles: ready alternates, two transfers.
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_num_i = 16'd1; cfg_den_i = 16'd3;
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
            rdy[i] = cfg_ready_o;
            if (cfg_ready_o) xfers++;
            step();
        end
        cfg_valid_i = 1'b0;
        check("hs_ready0", rdy[0], 1);
        check("hs_ready1", rdy[1], 0);
        check("hs_ready2", rdy[2], 1);
        check("hs_ready3", rdy[3], 0);
        check("hs_xfers", xfers, 2);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (clken_o[0]) begin
                first = k;
                break;
            end
        end
        check("hs_next_pulse", first, 2);

        // Lock loss and re-lock with retained ratios.
        pll_locked_i = 1'b0;
        wait_locked(1'b0, e);
        check("loss_latency", e, 3);
        check("loss_clken", clken_o, 0);
        for (int i = 0; i < 4; i++) step();
        pll_locked_i = 1'b1;
        wait_locked(1'b1, e);
        check("relock_latency", e, 2 + 1 + LC);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (clken_o[0]) begin
                first = k;
                break;
            end
        end
        check("relock_first", first, 3);

        // Asynchronous reset in the middle of SETTLE.
        pll_locked_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        pll_locked_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", cfg_ready_o, 0);
        check("arst_locked", locked_o, 0);
        check("arst_clken", clken_o, 0);
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        wait_locked(1'b1, e);
        check("post_rst_lock", e, 2 + 1 + LC);

        // Randomized traffic with occasional lock drops.
        drop_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(cfg_valid_i && !m_ready)) begin
                cfg_valid_i = ($urandom_range(0, 3) == 0);
                cfg_ch_i    = CH_W'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0:       cfg_den_i = '0;
                    1:       cfg_den_i = ACC_W'($urandom_range(0, 65535));
                    default: cfg_den_i = ACC_W'($urandom_range(1, 16));
                endcase
                if ($urandom_range(0, 4) == 0) cfg_num_i = ACC_W'($urandom_range(0, 65535));
                else cfg_num_i = ACC_W'($urandom_range(0, int'(cfg_den_i) + 2));
            end
            if (drop_left > 0) begin
                drop_left--;
                pll_locked_i = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                drop_left = $urandom_range(1, 14);
                pll_locked_i = 1'b0;
            end else begin
                pll_locked_i = 1'b1;
            end
            step();
        end
        cfg_valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
